// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake, two-entry skid buffer and flush
// in_ready and out_valid decode from the state register alone, so neither handshake input reaches an output combinationally.
module pipe_stage_reg #(
    parameter int unsigned               data_width  = 32,
    parameter logic [data_width-1:0]     reset_value = data_width'(32'h0000_0000),
    parameter logic [data_width-1:0]     flush_value = data_width'(32'h0000_0013)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [data_width-1:0] main_q;
    logic [data_width-1:0] main_d;
    logic [data_width-1:0] skid_q;
    logic [data_width-1:0] skid_d;
    logic                  do_accept;
    logic                  do_release;

    assign do_accept  = in_valid && in_ready;
    assign do_release = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            main_q <= reset_value;
            skid_q <= '0;
        end else begin
            state  <= state_next;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Flush overrides every handshake; the skid word is left stale since EMPTY never reads it.
    always_comb begin
        state_next = state;
        main_d     = main_q;
        skid_d     = skid_q;
        if (flush) begin
            state_next = EMPTY;
            main_d     = flush_value;
        end else begin
            case (state)
                EMPTY: begin
                    if (do_accept) begin
                        state_next = ONE;
                        main_d     = in_data;
                    end
                end
                ONE: begin
                    if (do_accept && do_release) begin
                        main_d = in_data;
                    end else if (do_accept) begin
                        state_next = TWO;
                        skid_d     = in_data;
                    end else if (do_release) begin
                        state_next = EMPTY;
                        main_d     = flush_value;
                    end
                end
                TWO: begin
                    if (do_release) begin
                        state_next = ONE;
                        main_d     = skid_q;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_d     = flush_value;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = (state != TWO);
        out_data  = main_q;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule
